// File: rtl/dff_bist_pkg.sv
// Shared definitions for the D flip-flop self-test sequencer.
//   state_t        : sequencer states
//   LFSR_TAPS      : feedback taps of x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   RST_DUT_CYCLES : cycles the cell is held in reset before data starts
//   lfsr_next()    : one Fibonacci shift-left step
package dff_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_DUT,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [7:0] LFSR_TAPS      = 8'hB8;
  localparam int         RST_DUT_CYCLES = 2;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR pattern source.
//   clk, rst : clock, asynchronous active-high reset (state returns to SEED)
//   load     : load seed (wins over step)
//   seed     : value loaded by load
//   step     : advance one shift
//   state    : current register contents; bit 7 is the outgoing pattern bit
module lfsr8
  import dff_bist_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] state
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/dff_bist.sv
// Built-in self-test sequencer for the D flip-flop cell.
// Drives the cell's d and reset with an LFSR pattern, checks q/q_bar against
// the one-cycle-delayed data and reports a pass flag and saturating error count.
//   clk, rst   : shared clock, asynchronous active-high reset
//   start      : run request, only honoured in IDLE
//   d_out      : data to the cell d (registered)
//   dut_rst_n  : active-low reset to the cell (registered)
//   q_in       : cell q
//   q_bar_in   : cell q_bar
//   busy       : run in progress (not IDLE, not DONE)
//   done       : one-cycle pulse at the end of a run
//   pass       : verdict of the last run, held until the next start
//   err_count  : saturating mismatch count of the last/current run
module dff_bist
  import dff_bist_pkg::*;
#(
  parameter int         NUM_VECTORS = 64,
  parameter logic [7:0] SEED        = 8'hA5,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             d_out,
  output logic             dut_rst_n,
  input  logic             q_in,
  input  logic             q_bar_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0]       LAST_VEC = 8'(NUM_VECTORS - 1);
  localparam logic [7:0]       LAST_RST = 8'(RST_DUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  state_t           state, state_nxt;
  logic [7:0]       cnt;        // cycle index within RST_DUT or RUN
  logic [7:0]       lfsr;
  logic             lfsr_msb;
  logic [6:0]       lfsr_unused; // low bits only feed the LFSR's own feedback
  logic             d_exp;      // d_out of the previous cycle = expected q now
  logic             start_run;
  logic             chk_en;
  logic             chk_ok;
  logic [CNT_W-1:0] err_nxt;

  assign {lfsr_msb, lfsr_unused} = lfsr;

  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_run),
    .seed  (SEED),
    .step  (state_nxt == RUN),
    .state (lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    chk_en    = 1'b0;
    chk_ok    = 1'b1;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RST_DUT;
          start_run = 1'b1;
        end
      end
      RST_DUT: begin
        if (cnt == LAST_RST) begin
          // Last reset cycle: the cell must be showing its reset value.
          chk_en    = 1'b1;
          chk_ok    = (q_in == 1'b0) && (q_bar_in == 1'b1);
          state_nxt = RUN;
        end
      end
      RUN: begin
        // The first RUN cycle still shows the reset value, so no check.
        if (cnt != 8'd0) begin
          chk_en = 1'b1;
          chk_ok = (q_in == d_exp) && (q_bar_in != q_in);
        end
        if (cnt == LAST_VEC) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Checks the vector driven in the last RUN cycle.
        chk_en    = 1'b1;
        chk_ok    = (q_in == d_exp) && (q_bar_in != q_in);
        state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One error at most per checked cycle, saturating.
  always_comb begin
    err_nxt = err_count;
    if (start_run) begin
      err_nxt = '0;
    end else if (chk_en && !chk_ok && (err_count != ERR_MAX)) begin
      err_nxt = err_count + CNT_W'(1);
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 8'd0;
      d_out     <= 1'b0;
      dut_rst_n <= 1'b0;
      d_exp     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      err_count <= err_nxt;
      d_exp     <= d_out;
      dut_rst_n <= (state_nxt != RST_DUT);
      busy      <= !(state_nxt inside {IDLE, DONE});
      done      <= (state_nxt == DONE);

      if (start_run)               pass <= 1'b0;
      else if (state_nxt == DONE)  pass <= (err_nxt == '0);

      if (state_nxt == RST_DUT)    d_out <= 1'b0;
      else if (state_nxt == RUN)   d_out <= lfsr_msb;

      if (state_nxt != state)                    cnt <= 8'd0;
      else if (state inside {RST_DUT, RUN})      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dff_bist.sv
// Self-checking bench for dff_bist. Three sequencers run against behavioural
// flip-flop cells with selectable faults:
//   dut0: defaults (64 vectors, 8-bit count)
//   dut1: 64 vectors, 4-bit count (saturation)
//   dut2: 1 vector (shortest run, reset mid-run)
// Expected results come from the LFSR expansion and simple counting rules.
module tb_dff_bist;

  localparam int F_IDEAL   = 0;
  localparam int F_STUCK0  = 1;
  localparam int F_STUCK1  = 2;
  localparam int F_QB_EQ_Q = 3;

  localparam int S_DOUT = 0, S_DRSTN = 1, S_BUSY = 2, S_DONE = 3, S_PASS = 4, S_ERR = 5;

  typedef struct {
    int inst;
    int e0;    // cycle index of the edge that samples start
    int lat;
    int errs;
    int pass;
  } exp_t;

  typedef struct {
    int cyc;
    int inst;
    int sig;
    int val;
  } probe_t;

  logic clk;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic rst [3];
  logic start [3];
  logic d_out [3];
  logic dut_rst_n [3];
  logic q_in [3];
  logic q_bar_in [3];
  logic busy [3];
  logic done [3];
  logic pass [3];
  logic q_ff [3];
  int   fault [3];
  logic [7:0] err0;
  logic [3:0] err1;
  logic [7:0] err2;

  exp_t   sb[$];
  probe_t pq[$];
  exp_t   cur;
  int     found;
  int     pk;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dff_bist #(.NUM_VECTORS(64), .SEED(8'hA5), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .d_out(d_out[0]), .dut_rst_n(dut_rst_n[0]),
    .q_in(q_in[0]), .q_bar_in(q_bar_in[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err0));

  dff_bist #(.NUM_VECTORS(64), .SEED(8'hA5), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .d_out(d_out[1]), .dut_rst_n(dut_rst_n[1]),
    .q_in(q_in[1]), .q_bar_in(q_bar_in[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err1));

  dff_bist #(.NUM_VECTORS(1), .SEED(8'hA5), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .d_out(d_out[2]), .dut_rst_n(dut_rst_n[2]),
    .q_in(q_in[2]), .q_bar_in(q_bar_in[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_count(err2));

  // Behavioural cells: ideal DFF with async active-low reset, plus fault injection.
  for (genvar g = 0; g < 3; g++) begin : g_cell
    always @(posedge clk or negedge dut_rst_n[g]) begin
      if (!dut_rst_n[g]) q_ff[g] <= 1'b0;
      else               q_ff[g] <= d_out[g];
    end
    assign q_in[g]     = (fault[g] == F_STUCK0) ? 1'b0 :
                         (fault[g] == F_STUCK1) ? 1'b1 : q_ff[g];
    assign q_bar_in[g] = (fault[g] == F_QB_EQ_Q) ? q_in[g] : ~q_ff[g];
  end

  function automatic int nv_of(input int i);
    return (i == 2) ? 1 : 64;
  endfunction

  function automatic int cw_of(input int i);
    return (i == 1) ? 4 : 8;
  endfunction

  // Bit k = the k-th data bit sent: MSB of the register, then one LFSR step.
  function automatic logic [255:0] expansion(input int n);
    logic [7:0]   s;
    logic [255:0] v;
    s = 8'hA5;
    v = '0;
    for (int k = 0; k < n; k++) begin
      v[k] = s[7];
      s    = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    return v;
  endfunction

  // Reset check + one check per vector, at most one error each, saturating.
  function automatic int exp_errors(input int f, input int n, input int cw);
    logic [255:0] b;
    int ones;
    int e;
    b    = expansion(n);
    ones = 0;
    for (int k = 0; k < n; k++) ones += int'(b[k]);
    case (f)
      F_STUCK0:  e = ones;
      F_STUCK1:  e = 1 + (n - ones);
      F_QB_EQ_Q: e = n + 1;
      default:   e = 0;
    endcase
    if (e > (1 << cw) - 1) e = (1 << cw) - 1;
    return e;
  endfunction

  function automatic logic [31:0] sig_val(input int i, input int s);
    case (s)
      S_DOUT:  return 32'(d_out[i]);
      S_DRSTN: return 32'(dut_rst_n[i]);
      S_BUSY:  return 32'(busy[i]);
      S_DONE:  return 32'(done[i]);
      S_PASS:  return 32'(pass[i]);
      default: return (i == 0) ? 32'(err0) : (i == 1) ? 32'(err1) : 32'(err2);
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      S_DOUT:  return "d_out";
      S_DRSTN: return "dut_rst_n";
      S_BUSY:  return "busy";
      S_DONE:  return "done";
      S_PASS:  return "pass";
      default: return "err_count";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pending(input int i);
    int c;
    c = 0;
    foreach (sb[k]) if (sb[k].inst == i) c++;
    return c;
  endfunction

  // Scoreboard entry plus per-cycle probes for a run whose start edge is e0.
  task automatic push_run(input int i, input int e0, input int f);
    int n;
    int e;
    logic [255:0] b;
    n = nv_of(i);
    e = exp_errors(f, n, cw_of(i));
    b = expansion(n);
    sb.push_back('{inst: i, e0: e0, lat: n + 4, errs: e, pass: int'(e == 0)});
    pq.push_back('{cyc: e0,         inst: i, sig: S_BUSY,  val: 1});
    pq.push_back('{cyc: e0,         inst: i, sig: S_ERR,   val: 0});
    pq.push_back('{cyc: e0,         inst: i, sig: S_DRSTN, val: 0});
    pq.push_back('{cyc: e0 + 1,     inst: i, sig: S_DRSTN, val: 0});
    pq.push_back('{cyc: e0 + 2,     inst: i, sig: S_DRSTN, val: 1});
    for (int k = 0; k < 8 && k < n; k++)
      pq.push_back('{cyc: e0 + 2 + k, inst: i, sig: S_DOUT, val: int'(b[k])});
    pq.push_back('{cyc: e0 + n + 3, inst: i, sig: S_BUSY, val: 0});
    pq.push_back('{cyc: e0 + n + 4, inst: i, sig: S_DONE, val: 0});
    pq.push_back('{cyc: e0 + n + 4, inst: i, sig: S_PASS, val: int'(e == 0)});
  endtask

  task automatic abort(input int i);
    int k;
    k = 0;
    while (k < sb.size()) if (sb[k].inst == i) sb.delete(k); else k++;
    k = 0;
    while (k < pq.size()) if (pq[k].inst == i) pq.delete(k); else k++;
  endtask

  task automatic run(input int i, input int f);
    @(negedge clk);
    fault[i] = f;
    push_run(i, cyc + 1, f);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int b;
    b = budget;
    while (pending(i) != 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    check($sformatf("dut%0d_runs_pending", i), pending(i), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset(input int i);
    check($sformatf("dut%0d_rst_busy", i),      busy[i],      0);
    check($sformatf("dut%0d_rst_done", i),      done[i],      0);
    check($sformatf("dut%0d_rst_pass", i),      pass[i],      0);
    check($sformatf("dut%0d_rst_err", i),       sig_val(i, S_ERR), 0);
    check($sformatf("dut%0d_rst_d_out", i),     d_out[i],     0);
    check($sformatf("dut%0d_rst_dut_rst_n", i), dut_rst_n[i], 0);
  endtask

  task automatic back_to_back(input int i, input int f);
    int n;
    int e0;
    n = nv_of(i);
    @(negedge clk);
    fault[i] = f;
    e0 = cyc + 1;
    push_run(i, e0, f);
    push_run(i, e0 + n + 5, f);  // one IDLE cycle after DONE
    start[i] = 1'b1;
    repeat (n + 8) @(negedge clk);
    start[i] = 1'b0;
    wait_done(i, 2 * n + 30);
  endtask

  // Monitor: consumes scoreboard entries on done, and due probes every cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (done[g] === 1'b1) begin
        found = -1;
        for (int k = 0; k < sb.size(); k++)
          if (found < 0 && sb[k].inst == g) found = k;
        check($sformatf("dut%0d_done_expected", g), 32'(found >= 0), 1);
        if (found >= 0) begin
          cur = sb[found];
          sb.delete(found);
          check($sformatf("dut%0d_latency", g),   cyc - cur.e0 + 1, cur.lat);
          check($sformatf("dut%0d_err_count", g), sig_val(g, S_ERR), cur.errs);
          check($sformatf("dut%0d_pass", g),      pass[g], cur.pass);
        end
      end
    end
    pk = 0;
    while (pk < pq.size()) begin
      if (pq[pk].cyc == cyc) begin
        check($sformatf("dut%0d_%s_at_%0d", pq[pk].inst, sig_name(pq[pk].sig), cyc),
              sig_val(pq[pk].inst, pq[pk].sig), pq[pk].val);
        pq.delete(pk);
      end else begin
        pk++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int f;
    int r;
    for (int k = 0; k < 3; k++) begin
      rst[k]   = 1'b1;
      start[k] = 1'b0;
      fault[k] = F_IDEAL;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check_reset(k);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    repeat (2) @(negedge clk);
    check("dut0_idle_dut_rst_n", dut_rst_n[0], 1);

    // Clean cell, stuck q, broken inversion, saturation.
    run(0, F_IDEAL);   wait_done(0, 100);
    run(0, F_STUCK0);  wait_done(0, 100);
    run(0, F_QB_EQ_Q); wait_done(0, 100);
    run(1, F_STUCK1);  wait_done(1, 100);

    // start during RUN must not restart; done keeps its original time.
    run(0, F_IDEAL);
    repeat (20) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 100);

    back_to_back(0, F_IDEAL);
    back_to_back(2, F_STUCK0);

    // Reset during RUN of the 1-vector sequencer, then a fresh run.
    run(2, F_QB_EQ_Q);           // now in cycle e0 (first RST_DUT cycle)
    repeat (2) @(negedge clk);   // cycle e0+2: RUN, reset check already failed
    check("dut2_busy_in_run", busy[2], 1);
    check("dut2_err_after_rst_check", sig_val(2, S_ERR), 1);
    abort(2);
    rst[2] = 1'b1;
    #1;
    check_reset(2);
    @(negedge clk);
    rst[2] = 1'b0;
    run(2, F_IDEAL);
    wait_done(2, 30);

    // Randomised runs with occasional ignored start pulses.
    for (int it = 0; it < 10; it++) begin
      i = $urandom_range(0, 2);
      f = $urandom_range(0, 3);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(i, f);
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(1, nv_of(i) + 3);
        repeat (r - 1) @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
      end
      wait_done(i, nv_of(i) + 30);
    end

    repeat (4) @(negedge clk);
    check("probes_left", pq.size(), 0);
    check("runs_left", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_bist.md
# dff_bist

Built-in self-test sequencer for the gate-level D flip-flop cell. It sits directly around the cell: upstream it drives the cell's `d` and active-low reset with an LFSR pattern, and downstream it samples `q`/`q_bar` and checks them against the expected one-cycle-delayed data. The result is a pass flag and a saturating error count for the chip-level status register.

## Interface
Parameters:
- `NUM_VECTORS`, default 64: data vectors per run, legal range 1..255.
- `SEED`, default 8'hA5: LFSR load value at each start. Must be nonzero.
- `CNT_W`, default 8: width of `err_count`.

Ports:
- `clk`, input, 1: single clock, shared with the cell under test.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: run request, sampled in IDLE only.
- `d_out`, output, 1: data to the cell `d`.
- `dut_rst_n`, output, 1: active-low reset to the cell.
- `q_in`, input, 1: cell `q`.
- `q_bar_in`, input, 1: cell `q_bar`.
- `busy`, output, 1: high in every state except IDLE and DONE.
- `done`, output, 1: one-cycle pulse at the end of a run.
- `pass`, output, 1: run verdict, held until the next `start`.
- `err_count`, output, `CNT_W`: mismatches in the last or current run.

## Operation
- Reset values while `rst` is high:
  - state IDLE
  - `d_out`=0, `dut_rst_n`=0
  - `busy`=0, `done`=0, `pass`=0, `err_count`=0
  - LFSR=`SEED`, vector counter=0
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Each step shifts left; bit0 takes lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3].
  - `d_out` is lfsr[7], registered.
- FSM states: IDLE, RST_DUT, RUN, DRAIN, DONE.
- **IDLE**
  - `dut_rst_n`=1.
  - `start`=1 → RST_DUT. On that transition: clear `err_count` and `pass`, load LFSR=`SEED`.
- **RST_DUT** (exactly 2 cycles)
  - `dut_rst_n`=0, `d_out`=0.
  - In the 2nd cycle, check `q_in`==0 and `q_bar_in`==1. A mismatch adds 1 error.
  - → RUN.
- **RUN** (exactly `NUM_VECTORS` cycles)
  - `dut_rst_n`=1. `d_out` presents a new LFSR bit each cycle; the LFSR steps each cycle.
  - A one-bit register `d_exp` holds the previous cycle's `d_out`.
  - From the 2nd RUN cycle on, check `q_in`==`d_exp` and `q_bar_in`==~`q_in`.
  - → DRAIN after the last vector.
- **DRAIN** (1 cycle)
  - Performs the check for the final vector. `d_out` holds.
  - → DONE.
- **DONE** (1 cycle)
  - `done`=1.
  - `pass`=1 iff `err_count`==0.
  - → IDLE.
- Error counting:
  - At most +1 per checked cycle, even if both `q` and `q_bar` are wrong.
  - Saturates at 2^`CNT_W`−1.
  - Total checks per run = `NUM_VECTORS`+1.
- Boundary conditions:
  - `start` outside IDLE is ignored; it does not restart or queue.
  - `rst` mid-run returns immediately to reset values. The cell is held in reset via `dut_rst_n`=0.
  - `start` high continuously re-runs back to back, with one IDLE cycle between runs.

## Timing
- `start` is sampled at edge E0. RST_DUT occupies cycles E0+1..E0+2. RUN starts at E0+3.
- Data delay: the value driven on `d_out` in cycle n must appear on `q_in` in cycle n+1 (the cell captures on the shared rising edge). It is compared at the edge ending cycle n+1.
- Run length from `start` edge to `done` pulse: `NUM_VECTORS`+4 cycles. Example: 68 cycles at default `NUM_VECTORS`=64.
- Output timing:
  - `err_count` updates on the edge after each failing check.
  - `pass` becomes valid in the same cycle as `done`.
- All outputs are registered. There is no combinational path from `q_in`/`q_bar_in` to any output.

## Structure
- Package `dff_bist_pkg` holds:
  - the state enum (IDLE, RST_DUT, RUN, DRAIN, DONE)
  - the LFSR tap constant
  - the RST_DUT length constant (2)
- Sub-module `lfsr8` contains:
  - inputs: `clk`, `rst`, `load`, `seed`, `step`
  - output: `state[7:0]`
  - behaviour: reset to `SEED`; `load` has priority over `step`.

## Test plan
- Ideal behavioural DFF model, defaults → `done` pulses 68 cycles after `start`; `pass`=1; `err_count`=0. The first 8 `d_out` bits match the LFSR expansion of 8'hA5.
- Cell `q` stuck at 0 → `err_count` equals the number of 1s among the 64 expected bits; `pass`=0.
- `q_bar` tied equal to `q` (inversion broken) → `err_count`=65 (64 data checks plus the reset check); `pass`=0.
- `CNT_W`=4 with `q` stuck at 1 → `err_count` saturates at 15.
- `start` pulsed during RUN → no restart; `done` arrives at the original time.
- `rst` asserted mid-RUN, then a new `start` → outputs return to reset values; `dut_rst_n`=0 during `rst`. The new run with `NUM_VECTORS`=1 completes in 5 cycles with `pass`=1.
